// File: rtl/rca_chunk_sequencer.sv
// rca_chunk_sequencer: computes a WIDTH-bit unsigned add by driving one
// external CHUNK-bit ripple-carry adder for WIDTH/CHUNK cycles.
// Ports:
//   clk, rst       - clock, async active-high reset
//   start, a, b,   - request and operands (captured on accepted start)
//   cin
//   busy, done     - handshake (busy in RUN/DONE, done one-cycle pulse)
//   sum            - {carry_out, sum}, held until the next completion
//   add_a, add_b,  - operands to the external RCA slice (0 outside RUN)
//   add_cin
//   add_sum,       - combinational results from the RCA slice
//   add_cout
module rca_chunk_sequencer #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum,
    output logic [CHUNK-1:0] add_a,
    output logic [CHUNK-1:0] add_b,
    output logic             add_cin,
    input  logic [CHUNK-1:0] add_sum,
    input  logic             add_cout
);

    localparam int NCH = WIDTH / CHUNK;
    // Keep the index at least one bit wide so NCH==1 still elaborates.
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH:0]   sum_q, sum_d;

    // Slice result placed in the top CHUNK bits; written as a shift so the
    // CHUNK==WIDTH case needs no zero-width concatenation.
    logic [WIDTH-1:0] ins;
    assign ins = WIDTH'(add_sum) << (WIDTH - CHUNK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_q[CHUNK-1:0];
                add_b   = b_q[CHUNK-1:0];
                add_cin = carry_q;
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                acc_d   = (acc_q >> CHUNK) | ins;
                carry_d = add_cout;
                idx_d   = idx_q + IW'(1);
                // Only this edge writes sum, so it never glitches mid-run.
                if (idx_q == LAST) begin
                    sum_d   = {add_cout, acc_d};
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum = sum_q;

endmodule

// File: doc/rca_chunk_sequencer.md
Name: rca_chunk_sequencer

Overview:
- Multi-cycle controller that computes a WIDTH-bit add by driving one external CHUNK-bit ripple-carry adder (RCA) for WIDTH/CHUNK consecutive cycles.
- Carry is registered between chunks, so a small RCA instance can serve a wide operand.
- Sits between the operand source (switches or a register file) and the display driver; presents a start/busy/done handshake upstream and a held result downstream.

Parameters:
- WIDTH, 32, operand width in bits. Must be an integer multiple of CHUNK.
- CHUNK, 8, width of the external RCA slice. 1 <= CHUNK <= WIDTH.
- NCH (localparam), WIDTH/CHUNK, number of chunk cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- cin  in  1  carry-in; captured on the accepted start edge.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH+1  result {carry_out, sum}; held until the next completion.
- add_a  out  CHUNK  to RCA operand a.
- add_b  out  CHUNK  to RCA operand b.
- add_cin  out  1  to RCA carry-in.
- add_sum  in  CHUNK  from RCA sum; combinational, same cycle.
- add_cout  in  1  from RCA carry-out; combinational, same cycle.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; a_reg, b_reg, acc, carry_reg, idx, sum all 0; busy=0, done=0.
  - Takes effect immediately, mid-operation included. An aborted operation produces no done pulse, and sum reads 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: a_reg<=a, b_reg<=b, carry_reg<=cin, idx<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - Combinational outputs: add_a=a_reg[CHUNK-1:0], add_b=b_reg[CHUNK-1:0], add_cin=carry_reg.
  - Each edge:
    - a_reg and b_reg shift right by CHUNK (zero fill).
    - acc shifts right by CHUNK, with add_sum entering at the top CHUNK bits.
    - carry_reg<=add_cout; idx<=idx+1.
  - On the edge where idx==NCH-1: sum<={add_cout, next acc value}, go to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- start is ignored in RUN and DONE; no queuing. A start that is still high in the first IDLE cycle is accepted.
- Latency: done is high during the cycle following the NCH-th edge after the accepted start edge. With the default parameters, done asserts 4 edges after the start edge.
- Throughput: one operation per NCH+2 cycles.
- sum is stable everywhere except the final RUN edge, which is the only edge that writes it. It does not glitch during RUN.
- add_a, add_b and add_cin are 0 outside RUN.
- Width rule: sum[WIDTH] = carry out of the top chunk. No overflow flag; operands are unsigned.
- NCH==1 (CHUNK==WIDTH): a single RUN cycle, then DONE.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge. Required: busy=0, done=0, sum=0, add_* = 0 immediately.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0, start pulse.
  - add_cin sequence across RUN = 0,1,1,1.
  - done on the 4th edge after start.
  - sum=0x1_00000000.
- Carry-in: a=0x12345678, b=0x11111111, cin=1.
  - sum=0x0_2345678A.
  - done exactly one cycle wide.
  - busy high for 5 cycles.
- Busy-ignore:
  - First op: a=5, b=7. Then start with a=0xFFFFFFFF during RUN and again during DONE.
  - Required: sum=0x0_0000000C; the extra starts cause no second operation.
- Reset mid-operation:
  - Assert rst after 2 RUN edges.
  - Required: no done; sum=0; state=IDLE.
  - A following op a=1, b=2 yields sum=3 with normal latency.
- Parameter corner: CHUNK=32, WIDTH=32, a=0x80000000, b=0x80000000.
  - done 1 edge after start.
  - sum=0x1_00000000.
